// File: rtl/instruction_utilities.sv
// Shared types for the instruction front end: fetch queue entry, fetch
// controller state and small address helpers.
package instruction_utilities;

   // One buffered fetch result; a faulted entry carries a zero instruction word.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        fault;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      FETCH_RUN  = 1'b0,
      FETCH_HALT = 1'b1
   } fetch_state_t;

   // Canonical no-op (addi x0, x0, 0), kept here for reference by other blocks.
   localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

   // Fetch addresses are always word aligned; the low two bits are dropped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_fifo.sv
// In-order queue of fetch entries with flush. The head entry is held in its
// own register so the decoder-facing outputs come straight from flops.
module fetch_fifo
   import instruction_utilities::*;
#(
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  fetch_entry_t  din_i,
   input  logic          pop_i,
   output fetch_entry_t  head_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [CW-1:0] count_o
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  head_q, head_d;
   logic [PW-1:0] rd_q, wr_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          vld_q;

   // Next head: the freshly pushed word when nothing else remains, otherwise
   // the oldest stored word after an optional pop.
   always_comb begin
      rd_d   = rd_q + PW'(pop_i);
      cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);
      head_d = head_q;
      if (cnt_d != '0) begin
         if (push_i && ((cnt_q - CW'(pop_i)) == '0)) head_d = din_i;
         else                                       head_d = mem_q[rd_d];
      end
   end

   // Entry storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= din_i;
   end

   // Pointers, count, head register and head-valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
         head_q <= '0;
      end else if (flush_i) begin
         rd_q   <= '0;
         wr_q   <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_q + PW'(push_i);
         cnt_q  <= cnt_d;
         vld_q  <= (cnt_d != '0);
         head_q <= head_d;
      end
   end

   assign head_o  = head_q;
   assign empty_o = !vld_q;
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch: issues word requests under a credit limit,
// buffers responses in order and hands them to the decoder over the
// active-low n_irdy / n_stall handshake. Redirects flush and refetch; a bus
// error halts fetching until the next redirect.
module instruction_fetch_unit
   import instruction_utilities::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err,
   output logic [31:0] instruction,
   output logic [31:0] inst_pc,
   output logic        fetch_fault,
   output logic        n_irdy,
   input  logic        n_stall
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;

   fetch_state_t  state_q, state_d;
   logic          req_q, req_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] disc_q, disc_d;
   logic [CW-1:0] occ;
   logic [SW-1:0] occ_n, sum_n;
   logic          accept, keep, push, pop, q_empty, q_full;
   fetch_entry_t  entry, head;

   // A redirect withdraws the pending request in the same cycle.
   assign imem_req  = req_q && !redirect;
   assign imem_addr = pc_q;
   assign accept    = imem_req && imem_gnt;
   assign keep      = imem_rvalid && (disc_q == '0) && !redirect;
   assign push      = keep && (!q_full || pop);
   assign pop       = !q_empty && n_stall && !redirect;
   assign entry     = '{inst: (imem_err ? 32'h0 : imem_rdata), pc: rsp_pc_q, fault: imem_err};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect),
      .push_i  (push),
      .din_i   (entry),
      .pop_i   (pop),
      .head_o  (head),
      .empty_o (q_empty),
      .full_o  (q_full),
      .count_o (occ)
   );

   // Fetch control: PC tracking, in-flight / discard accounting, halt on
   // error, and a request only while buffered plus in-flight words leave room.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      disc_d   = disc_q;
      out_d    = out_q + CW'(accept) - CW'(imem_rvalid);
      occ_n    = SW'(occ) + SW'(push) - SW'(pop);
      if (accept) pc_d = pc_q + 32'd4;
      if (imem_rvalid && (disc_q != '0)) disc_d = disc_q - CW'(1);
      if (push) begin
         rsp_pc_d = rsp_pc_q + 32'd4;
         if (imem_err) state_d = FETCH_HALT;
      end
      if (redirect) begin
         state_d  = FETCH_RUN;
         pc_d     = word_align(redirect_pc);
         rsp_pc_d = word_align(redirect_pc);
         disc_d   = out_d;
         occ_n    = '0;
      end
      sum_n = occ_n + SW'(out_d);
      req_d = (req_q && !accept && !redirect) ||
              ((state_d == FETCH_RUN) && (sum_n < SW'(DEPTH)));
   end

   // Control registers; reset drops every in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FETCH_RUN;
         req_q    <= 1'b0;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         out_q    <= '0;
         disc_q   <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         out_q    <= out_d;
         disc_q   <= disc_d;
      end
   end

   assign instruction = head.inst;
   assign inst_pc     = head.pc;
   assign fetch_fault = head.fault;
   assign n_irdy      = q_empty;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a behavioural memory with random grant
// and latency, and a scoreboard of the words the decoder must receive.
module tb_instruction_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, redirect, imem_req, imem_gnt, imem_rvalid, imem_err;
   logic        fetch_fault, n_irdy, n_stall;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, instruction, inst_pc;

   instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .imem_err    (imem_err),
      .instruction (instruction),
      .inst_pc     (inst_pc),
      .fetch_fault (fetch_fault),
      .n_irdy      (n_irdy),
      .n_stall     (n_stall)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; bit stale; } pend_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } exp_t;
   typedef struct { logic [31:0] addr; int cyc; } glog_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; int cyc; } dlog_t;

   pend_t pend[$];   // requests accepted by memory, not yet answered
   exp_t  expq[$];   // words the decoder still has to receive, in order
   glog_t glog[$];   // accepted requests
   dlog_t dlog[$];   // words seen by the decoder (DUT values)

   int          n_vec = 0, n_err = 0, cyc = 0;
   int          gnt_pct = 100, rv_pct = 100, stall_pct = 0, err_pct = 0, lat_extra = 0;
   bit          data_is_addr = 1, err_en = 0, redir_now = 0, halted = 0, allow = 0;
   logic [31:0] err_at = '0, redir_pc = '0, req_pc = '0, obs_addr;
   logic        obs_req;
   int          g0, d0, rcyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = '0; n_stall = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_req",   32'(imem_req), 32'd0);
      check("rst_addr",  imem_addr, RESET_PC);
      check("rst_irdy",  32'(n_irdy), 32'd1);
      check("rst_inst",  instruction, 32'd0);
      check("rst_pc",    inst_pc, 32'd0);
      check("rst_fault", 32'(fetch_fault), 32'd0);
      rst = 1'b0;
      pend.delete(); expq.delete(); glog.delete(); dlog.delete();
      req_pc = RESET_PC; halted = 0; allow = 0; cyc = 1;
   endtask

   // One clock: drive memory/decoder, check outputs, then apply the
   // reference rules for what this edge does.
   task automatic step();
      pend_t       p;
      logic        rv, rerr;
      logic [31:0] rd;
      @(negedge clk);
      redirect = redir_now; redirect_pc = redir_pc; redir_now = 0;
      n_stall  = ($urandom_range(0, 99) >= stall_pct);
      imem_gnt = ($urandom_range(0, 99) < gnt_pct);
      rv = 1'b0; rerr = 1'b0; rd = '0;
      if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
         rv   = 1'b1;
         rerr = (err_en && pend[0].addr == err_at) || ($urandom_range(0, 99) < err_pct);
         rd   = data_is_addr ? pend[0].addr : $urandom;
      end
      imem_rvalid = rv; imem_err = rerr; imem_rdata = rd;
      #1;
      obs_req = imem_req; obs_addr = imem_addr;
      check("n_irdy", 32'(n_irdy), 32'(expq.size() == 0));
      if (expq.size() > 0) begin
         check("inst_pc",     inst_pc, expq[0].pc);
         check("instruction", instruction, expq[0].inst);
         check("fetch_fault", 32'(fetch_fault), 32'(expq[0].fault));
      end
      check("credit", 32'(pend.size() + expq.size() <= DEPTH), 32'd1);
      if (halted && !redirect) check("halt_req", 32'(imem_req), 32'(allow));
      // decoder transfer
      if (!redirect && n_stall && expq.size() > 0) begin
         dlog.push_back('{inst_pc, instruction, fetch_fault, cyc});
         void'(expq.pop_front());
      end
      // memory response
      if (rv) begin
         p = pend.pop_front();
         if (!p.stale && !redirect) begin
            expq.push_back('{p.addr, (rerr ? 32'h0 : rd), rerr});
            if (rerr) begin halted = 1; allow = imem_req && !imem_gnt; end
         end
      end
      // request acceptance
      if (imem_req && imem_gnt) begin
         check("imem_addr", imem_addr, req_pc);
         pend.push_back('{imem_addr, cyc + 1 + int'($urandom_range(0, lat_extra)), redirect});
         glog.push_back('{imem_addr, cyc});
         req_pc = req_pc + 32'd4;
         if (halted) allow = 0;
      end
      if (redirect) begin
         foreach (pend[i]) pend[i].stale = 1;
         expq.delete();
         req_pc = redir_pc & 32'hFFFF_FFFC;
         halted = 0; allow = 0;
      end
      @(posedge clk);
      cyc++;
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = '0; n_stall = 1'b1;

      // Streaming with a 1-cycle memory, address-as-data, no stalls
      do_reset();
      repeat (10) step();
      for (int i = 0; i < 5; i++) begin
         check("t1_gaddr", glog[i].addr, 32'(4 * i));
         check("t1_gcyc",  32'(glog[i].cyc), 32'(1 + i));
         check("t1_inst",  dlog[i].inst, 32'(4 * i));
         check("t1_dcyc",  32'(dlog[i].cyc), 32'(3 + i));
      end

      // Decoder stall for 10 cycles, then release
      stall_pct = 100;
      g0 = glog.size(); d0 = dlog.size();
      repeat (10) step();
      check("t2_grants_le", 32'((glog.size() - g0) <= DEPTH), 32'd1);
      check("t2_nodeliv",   32'(dlog.size() - d0), 32'd0);
      check("t2_req_off",   32'(obs_req), 32'd0);
      stall_pct = 0;
      repeat (10) step();
      for (int i = d0; i < d0 + 6; i++)
         check("t2_order", dlog[i].pc, dlog[i-1].pc + 32'd4);

      // Redirect with three requests in flight
      do_reset();
      rv_pct = 0;
      repeat (3) step();
      check("t3_inflight", 32'(pend.size()), 32'd3);
      redir_now = 1; redir_pc = 32'h0000_1003; rcyc = cyc;
      step();
      check("t3_req_in_R", 32'(obs_req), 32'd0);
      rv_pct = 100;
      repeat (12) step();
      check("t3_addr",  glog[3].addr, 32'h0000_1000);
      check("t3_gcyc",  32'(glog[3].cyc), 32'(rcyc + 1));
      check("t3_first", dlog[0].pc, 32'h0000_1000);

      // Bus error on 0x8 halts fetch until a redirect to 0x40
      do_reset();
      err_en = 1; err_at = 32'h8;
      repeat (12) step();
      check("t4_pc8",    dlog[2].pc, 32'h8);
      check("t4_fault",  32'(dlog[2].fault), 32'd1);
      check("t4_inst0",  dlog[2].inst, 32'd0);
      check("t4_pcC",    dlog[3].pc, 32'hC);
      check("t4_ngrant", 32'(glog.size()), 32'd4);
      check("t4_noreq",  32'(obs_req), 32'd0);
      err_en = 0;
      redir_now = 1; redir_pc = 32'h40;
      step();
      repeat (6) step();
      check("t4_resume", glog[4].addr, 32'h40);
      check("t4_deliv",  dlog[4].pc, 32'h40);

      // Grant withheld for 5 cycles, then reset mid-stall
      do_reset();
      gnt_pct = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_req",  32'(obs_req), 32'd1);
         check("t5_addr", obs_addr, RESET_PC);
      end
      do_reset();
      gnt_pct = 100;
      repeat (4) step();
      check("t5_restart", glog[0].addr, RESET_PC);

      // Fetch address wraps past 0xFFFF_FFFC
      redir_now = 1; redir_pc = 32'hFFFF_FFF9;
      g0 = glog.size();
      step();
      repeat (6) step();
      check("t6_a0", glog[g0].addr,   32'hFFFF_FFF8);
      check("t6_a1", glog[g0+1].addr, 32'hFFFF_FFFC);
      check("t6_a2", glog[g0+2].addr, 32'h0000_0000);

      // Random traffic: grant, latency, stalls, errors and redirects
      do_reset();
      data_is_addr = 0; lat_extra = 3;
      gnt_pct = 70; rv_pct = 70; stall_pct = 30; err_pct = 3;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            redir_now = 1;
            redir_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
